// File: rtl/div_arb_pkg.sv
// Shared types and default constants for the divider-sharing arbiter.
package div_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } div_state_e;

    localparam int SIZE_DEF    = 4;
    localparam int FRAC_DEF    = 10;
    localparam int NREQ_DEF    = 4;
    localparam int DIV_LAT_DEF = 14;

    // Width needed to hold a latency countdown starting at lat-1.
    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_LAT_DEF);

endpackage

// File: rtl/div_share_arbiter_rr_pick.sv
// Combinational round-robin picker: the first valid requester after 'last' wins.
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req_valid,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic [NREQ-1:0]         grant_oh,
    output logic [$clog2(NREQ)-1:0] grant_idx,
    output logic                    grant_any
);

    localparam int IW = $clog2(NREQ);

    // Scan from the farthest candidate to the nearest so the nearest valid one overwrites.
    always_comb begin
        logic [IW-1:0] cand;
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IW'((int'(last) + k) % NREQ);
            if (req_valid[cand]) begin
                grant_oh       = '0;
                grant_oh[cand] = 1'b1;
                grant_idx      = cand;
                grant_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one external fixed-latency divider between NREQ requesters.
// Handshake: a request transfers in the cycle where req_valid[i] and req_ready[i] are
// both high; req_ready is a one-cycle pulse, only offered while idle, and the result
// returns later as a one-cycle rsp_valid[i] pulse with rsp_m/rsp_f/rsp_dz.
module div_share_arbiter
    import div_arb_pkg::*;
#(
    parameter int SIZE    = SIZE_DEF,
    parameter int FRAC    = FRAC_DEF,
    parameter int NREQ    = NREQ_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*SIZE-1:0] req_a,
    input  logic [NREQ*SIZE-1:0] req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [SIZE-1:0]      rsp_m,
    output logic [FRAC-1:0]      rsp_f,
    output logic                 rsp_dz,
    output logic                 busy,
    output logic                 div_start,
    output logic [SIZE-1:0]      div_a,
    output logic [SIZE-1:0]      div_b,
    input  logic [SIZE-1:0]      div_m,
    input  logic [FRAC-1:0]      div_f,
    output div_state_e           dbg_state
);

    localparam int IW    = $clog2(NREQ);
    localparam int CNT_W = cnt_width(DIV_LAT);

    div_state_e      state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   g_q, g_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SIZE-1:0] div_a_q, div_a_d;
    logic [SIZE-1:0] div_b_q, div_b_d;
    logic [SIZE-1:0] res_m_q, res_m_d;
    logic [FRAC-1:0] res_f_q, res_f_d;
    logic            res_dz_q, res_dz_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic            div_start_q, div_start_d;
    logic            busy_q, busy_d;
    // High while idle and out of reset for at least one edge; gates req_ready.
    logic            arm_q, arm_d;

    logic [NREQ-1:0] grant_oh;
    logic [IW-1:0]   grant_idx;
    logic            grant_any;
    logic [SIZE-1:0] sel_b;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req_valid (req_valid),
        .last      (last_q),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign sel_b     = req_b[grant_idx*SIZE +: SIZE];
    assign req_ready = arm_q ? grant_oh : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_m     = res_m_q;
    assign rsp_f     = res_f_q;
    assign rsp_dz    = res_dz_q;
    assign busy      = busy_q;
    assign div_start = div_start_q;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;
    assign dbg_state = state_q;

    // Next-state and registered-output computation for the sequencing FSM.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        g_d      = g_q;
        cnt_d    = cnt_q;
        div_a_d  = div_a_q;
        div_b_d  = div_b_q;
        res_m_d  = res_m_q;
        res_f_d  = res_f_q;
        res_dz_d = res_dz_q;
        case (state_q)
            IDLE: begin
                if (arm_q && grant_any) begin
                    g_d     = grant_idx;
                    div_a_d = req_a[grant_idx*SIZE +: SIZE];
                    div_b_d = sel_b;
                    if (sel_b == '0) begin
                        // Resolved locally; the divider is never started.
                        res_m_d  = '1;
                        res_f_d  = '0;
                        res_dz_d = 1'b1;
                        state_d  = DONE;
                    end else begin
                        res_dz_d = 1'b0;
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(DIV_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    res_m_d = div_m;
                    res_f_d = div_f;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                last_d  = g_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        rsp_valid_d = '0;
        if (state_d == DONE) begin
            rsp_valid_d[g_d] = 1'b1;
        end
        div_start_d = (state_d == ISSUE);
        busy_d      = (state_d != IDLE);
        arm_d       = (state_d == IDLE);
    end

    // State and output registers; reset drops any in-flight result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_q      <= IW'(NREQ - 1);
            g_q         <= '0;
            cnt_q       <= '0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            res_m_q     <= '0;
            res_f_q     <= '0;
            res_dz_q    <= 1'b0;
            rsp_valid_q <= '0;
            div_start_q <= 1'b0;
            busy_q      <= 1'b0;
            arm_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            g_q         <= g_d;
            cnt_q       <= cnt_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            res_m_q     <= res_m_d;
            res_f_q     <= res_f_d;
            res_dz_q    <= res_dz_d;
            rsp_valid_q <= rsp_valid_d;
            div_start_q <= div_start_d;
            busy_q      <= busy_d;
            arm_q       <= arm_d;
        end
    end

endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter with a behavioural fixed-latency divider alongside.
module tb_div_share_arbiter;
    import div_arb_pkg::*;

    localparam int SIZE    = 4;
    localparam int FRAC    = 10;
    localparam int NREQ    = 4;
    localparam int DIV_LAT = 14;
    // Entry: {idx[2:0], a, b, m, f, dz}
    localparam int W = 3 + SIZE + SIZE + SIZE + FRAC + 1;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*SIZE-1:0] req_a;
    logic [NREQ*SIZE-1:0] req_b;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [SIZE-1:0]      rsp_m;
    logic [FRAC-1:0]      rsp_f;
    logic                 rsp_dz;
    logic                 busy;
    logic                 div_start;
    logic [SIZE-1:0]      div_a;
    logic [SIZE-1:0]      div_b;
    logic [SIZE-1:0]      div_m;
    logic [FRAC-1:0]      div_f;
    div_state_e           dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [W-1:0] gnt_q[$];
    logic [W-1:0] exp_q[$];
    int           due_q[$];
    int           acc_cyc[NREQ];
    int           rsp_cyc[NREQ];
    logic         start_pending = 1'b0;
    int           start_cyc = 0;
    logic [NREQ-1:0] seen;

    div_share_arbiter #(
        .SIZE(SIZE), .FRAC(FRAC), .NREQ(NREQ), .DIV_LAT(DIV_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_m     (rsp_m),
        .rsp_f     (rsp_f),
        .rsp_dz    (rsp_dz),
        .busy      (busy),
        .div_start (div_start),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_m     (div_m),
        .div_f     (div_f),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got time %0t required finish earlier", $time);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- divider model ----------------
    // Outputs are junk until DIV_LAT cycles after the start cycle.
    logic [SIZE-1:0] da, db;
    int              dcnt;
    logic            darmed;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            da <= '0; db <= '0; dcnt <= 0; darmed <= 1'b0;
        end else if (div_start) begin
            da <= div_a; db <= div_b; dcnt <= DIV_LAT - 1; darmed <= 1'b1;
        end else if (darmed && dcnt != 0) begin
            dcnt <= dcnt - 1;
        end
    end

    always_comb begin
        div_m = 4'hC;
        div_f = 10'h3FF;
        if (darmed && dcnt == 0 && db != '0) begin
            div_m = da / db;
            div_f = FRAC'(((int'(da) % int'(db)) << FRAC) / int'(db));
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        seen = req_ready;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~seen;
    endtask

    task automatic send(input int idx, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                        input logic [SIZE-1:0] m, input logic [FRAC-1:0] f, input logic dz);
        logic [2:0] idx3;
        idx3 = 3'(idx);
        req_valid[idx]          = 1'b1;
        req_a[idx*SIZE +: SIZE] = a;
        req_b[idx*SIZE +: SIZE] = b;
        gnt_q.push_back({idx3, a, b, m, f, dz});
    endtask

    task automatic wait_drain(input int max_cyc);
        int n;
        n = 0;
        while ((gnt_q.size() != 0 || exp_q.size() != 0 || busy) && n < max_cyc) begin
            tick();
            n++;
        end
        checks++;
        if (n >= max_cyc) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending required 0", gnt_q.size() + exp_q.size());
            gnt_q.delete();
            exp_q.delete();
            due_q.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_m"},     32'(rsp_m), 0);
        chk({tag, "_rsp_f"},     32'(rsp_f), 0);
        chk({tag, "_rsp_dz"},    32'(rsp_dz), 0);
        chk({tag, "_busy"},      32'(busy), 0);
        chk({tag, "_div_start"}, 32'(div_start), 0);
        chk({tag, "_div_a"},     32'(div_a), 0);
        chk({tag, "_div_b"},     32'(div_b), 0);
        chk({tag, "_state"},     32'(dbg_state), 32'(IDLE));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        gnt_q.delete();
        exp_q.delete();
        due_q.delete();
        start_pending = 1'b0;
        repeat (2) tick();
        check_all_zero("reset");
        rst = 1'b1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [W-1:0] e;
        int           due;
        int           idx;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (req_ready != '0) begin
                    chk("grant_during_rsp", 32'(rsp_valid), 0);
                    if (gnt_q.size() == 0) begin
                        chk("unexpected_grant", 32'(req_ready), 0);
                    end else begin
                        e   = gnt_q.pop_front();
                        idx = int'(e[W-1 -: 3]);
                        chk("grant", 32'(req_ready), 32'(1) << idx);
                        acc_cyc[idx] = cyc;
                        if (e[0]) begin
                            due = cyc + 1;
                        end else begin
                            due = cyc + DIV_LAT + 2;
                            start_pending = 1'b1;
                            start_cyc = cyc + 1;
                        end
                        exp_q.push_back(e);
                        due_q.push_back(due);
                    end
                end
                if (div_start) begin
                    if (!start_pending) begin
                        chk("unexpected_start", 32'(div_start), 0);
                    end else begin
                        chk("start_cycle", 32'(cyc), 32'(start_cyc));
                        chk("busy_at_start", 32'(busy), 1);
                        start_pending = 1'b0;
                    end
                end
                if (rsp_valid != '0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 32'(rsp_valid), 0);
                    end else begin
                        e   = exp_q.pop_front();
                        due = due_q.pop_front();
                        idx = int'(e[W-1 -: 3]);
                        rsp_cyc[idx] = cyc;
                        chk("rsp_valid", 32'(rsp_valid), 32'(1) << idx);
                        chk("rsp_cycle", 32'(cyc), 32'(due));
                        chk("rsp_m",     32'(rsp_m), 32'(e[FRAC+SIZE : FRAC+1]));
                        chk("rsp_f",     32'(rsp_f), 32'(e[FRAC:1]));
                        chk("rsp_dz",    32'(rsp_dz), 32'(e[0]));
                        chk("div_a_hold", 32'(div_a), 32'(e[FRAC+3*SIZE : FRAC+2*SIZE+1]));
                        chk("div_b_hold", 32'(div_b), 32'(e[FRAC+2*SIZE : FRAC+SIZE+1]));
                        chk("busy_at_rsp", 32'(busy), 1);
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        seen      = '0;
        for (int i = 0; i < NREQ; i++) begin
            acc_cyc[i] = -100;
            rsp_cyc[i] = -100;
        end

        // Reset with every requester asking: nothing may be accepted.
        req_valid = '1;
        req_a     = 16'h5555;
        req_b     = 16'h1111;
        repeat (3) tick();
        check_all_zero("init");
        req_valid = '0;
        rst = 1'b1;
        tick();

        // Single request from requester 0.
        send(0, 4'd1, 4'd3, 4'd0, 10'd341, 1'b0);
        wait_drain(60);

        // Requester 2, then back-to-back a second one.
        send(2, 4'd10, 4'd3, 4'd3, 10'd341, 1'b0);
        wait_drain(60);
        send(2, 4'd9, 4'd3, 4'd3, 10'd0, 1'b0);
        wait_drain(60);

        // Divide by zero from requester 1.
        send(1, 4'd15, 4'd0, 4'd15, 10'd0, 1'b1);
        wait_drain(60);

        // All four at once after a reset: order 0,1,2,3.
        do_reset();
        send(0, 4'd8,  4'd2, 4'd4, 10'd0,   1'b0);
        send(1, 4'd7,  4'd2, 4'd3, 10'd512, 1'b0);
        send(2, 4'd5,  4'd4, 4'd1, 10'd256, 1'b0);
        send(3, 4'd12, 4'd5, 4'd2, 10'd409, 1'b0);
        wait_drain(200);

        // Requesters 0 and 2 together: 0 then 2.
        send(0, 4'd6,  4'd4, 4'd1, 10'd512, 1'b0);
        send(2, 4'd13, 4'd6, 4'd2, 10'd170, 1'b0);
        wait_drain(120);

        // Requester 3 raises valid while requester 0 is in WAIT.
        send(0, 4'd2, 4'd3, 4'd0, 10'd682, 1'b0);
        repeat (6) tick();
        chk("wait_state", 32'(dbg_state), 32'(WAIT));
        send(3, 4'd3, 4'd7, 4'd0, 10'd438, 1'b0);
        wait_drain(120);
        chk("late_grant_cycle", 32'(acc_cyc[3]), 32'(rsp_cyc[0] + 1));

        // Reset in the middle of WAIT: result discarded, outputs clear at once.
        send(1, 4'd9, 4'd2, 4'd4, 10'd512, 1'b0);
        repeat (6) tick();
        chk("pre_reset_state", 32'(dbg_state), 32'(WAIT));
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("mid");
        gnt_q.delete();
        exp_q.delete();
        due_q.delete();
        start_pending = 1'b0;
        send(0, 4'd14, 4'd4, 4'd3, 10'd512, 1'b0);
        send(1, 4'd9,  4'd2, 4'd4, 10'd512, 1'b0);
        tick();
        chk("ready_in_reset", 32'(req_ready), 0);
        tick();
        rst = 1'b1;
        wait_drain(120);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
